// File: rtl/pipe_egress_buffer_pkg.sv
// Shared constants for the egress buffer and the compute delay line that feeds it.
// Keeping the latency here lets both sides agree on PIPELEN by construction.
package pipe_egress_buffer_pkg;

    localparam int PIPE_LEN_DEFAULT = 4;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/egress_ring_mem.sv
// Circular register array with its own write and read pointers.
// Latency: write lands at the edge; read is combinational from the read pointer.
// Backpressure: none; the owner only asserts enables when a push/pop is legal.
module egress_ring_mem
    import pipe_egress_buffer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;

    // Power-of-two depth: pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/pipe_egress_buffer.sv
// Credit-managed drain buffer for a fixed-latency, non-stallable pipeline.
// Latency: an arrival in cycle t is presented in t+1; a popped credit is reusable next cycle.
// Backpressure: issuer is held off by credits; consumer stalls via out_ready without loss.
module pipe_egress_buffer
    import pipe_egress_buffer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int PIPELEN = PIPE_LEN_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        issue,
    output logic                        issue_ready,
    input  logic                        pipe_valid,
    input  logic [WIDTH-1:0]            pipe_data,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [clog2(DEPTH+1)-1:0]   count,
    output logic                        overflow_err
);

    localparam int CNT_W  = clog2(DEPTH + 1);
    localparam int DISC_W = clog2(PIPELEN + 1);

    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_credits;
    logic [DISC_W-1:0] r_discard;
    logic              r_overflow;

    logic w_pop;
    logic w_full;
    logic w_in_window;
    logic w_arrival;
    logic w_push;
    logic w_drop;
    logic w_issue_ok;
    logic w_issue_bad;
    logic w_credits_max;

    assign w_pop         = (r_count != '0) & out_ready;
    assign w_full        = (r_count == CNT_W'(DEPTH));
    assign w_in_window   = (r_discard != '0);
    assign w_arrival     = pipe_valid & ~w_in_window;
    // A full buffer still accepts an arrival when the same cycle frees a slot.
    assign w_push        = w_arrival & (~w_full | w_pop);
    assign w_drop        = w_arrival & w_full & ~w_pop;
    assign w_issue_ok    = issue & (r_credits != '0);
    assign w_issue_bad   = issue & (r_credits == '0);
    assign w_credits_max = (r_credits == CNT_W'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_credits  <= CNT_W'(DEPTH);
            r_discard  <= DISC_W'(PIPELEN);
            r_overflow <= 1'b0;
        end else begin
            if (w_in_window) begin
                r_discard <= r_discard - DISC_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Saturate at DEPTH so unsolicited arrivals cannot inflate the credit pool.
            if (w_issue_ok && !w_pop) begin
                r_credits <= r_credits - CNT_W'(1);
            end else if (!w_issue_ok && w_pop && !w_credits_max) begin
                r_credits <= r_credits + CNT_W'(1);
            end

            if (w_issue_bad || w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    egress_ring_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ring (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data (pipe_data),
        .i_rd_en   (w_pop),
        .o_rd_data (out_data)
    );

    assign issue_ready  = (r_credits != '0);
    assign out_valid    = (r_count != '0);
    assign count        = r_count;
    assign overflow_err = r_overflow;

endmodule

// File: tb/tb_pipe_egress_buffer.sv
// Directed bench: a modelled delay line feeds the buffer; a negedge monitor drains the scoreboard.
module tb_pipe_egress_buffer;

    localparam int W = 8;
    localparam int D = 8;
    localparam int P = 4;

    logic         clock;
    logic         reset;
    logic         issue;
    logic         issue_ready;
    logic         pipe_valid;
    logic [W-1:0] pipe_data;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [3:0]   count;
    logic         overflow_err;

    logic [W-1:0] issue_dat;
    logic         force_en;
    logic         force_vld;
    logic [W-1:0] force_dat;

    logic         dl_vld [P];
    logic [W-1:0] dl_dat [P];

    logic [W-1:0] sb_q [$];
    int           n_checks;
    int           n_errors;
    int           pop_cnt;
    logic         ir_drop;

    pipe_egress_buffer #(
        .WIDTH   (W),
        .DEPTH   (D),
        .PIPELEN (P)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .issue        (issue),
        .issue_ready  (issue_ready),
        .pipe_valid   (pipe_valid),
        .pipe_data    (pipe_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .count        (count),
        .overflow_err (overflow_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Fixed-latency pipeline model: only credited issues enter it.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < P; i++) begin
                dl_vld[i] <= 1'b0;
                dl_dat[i] <= '0;
            end
        end else begin
            dl_vld[0] <= issue && issue_ready;
            dl_dat[0] <= issue_dat;
            for (int i = 1; i < P; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_dat[i] <= dl_dat[i-1];
            end
        end
    end

    assign pipe_valid = force_en ? force_vld : dl_vld[P-1];
    assign pipe_data  = force_en ? force_dat : dl_dat[P-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            pop_cnt++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected: got %0h expected no item", out_data);
            end else begin
                check("pop_data", 32'(out_data), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        issue = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Issue 8 credited items back to back with the consumer stalled, then let them land.
    task automatic fill(input logic [W-1:0] base);
        out_ready = 1'b0;
        for (int k = 0; k < D; k++) begin
            issue     = 1'b1;
            issue_dat = base + W'(k);
            sb_q.push_back(base + W'(k));
            step();
        end
        issue = 1'b0;
        check("fill_credits_exhausted", 32'(issue_ready), 32'd0);
        repeat (P) step();
        check("fill_count_full", 32'(count), 32'd8);
        check("fill_head", 32'(out_data), 32'(base));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        pop_cnt   = 0;
        reset     = 1'b1;
        issue     = 1'b0;
        issue_dat = '0;
        out_ready = 1'b0;
        force_en  = 1'b0;
        force_vld = 1'b0;
        force_dat = '0;

        // 1: reset state and fill to capacity
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_overflow", 32'(overflow_err), 32'd0);
        fill(8'h01);

        // 2: drain in order
        out_ready = 1'b1;
        step();
        check("credit_back_after_pop", 32'(issue_ready), 32'd1);
        repeat (7) step();
        check("drain_count", 32'(count), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // 3: sustained streaming across pointer wrap
        pop_cnt = 0;
        ir_drop = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!issue_ready) ir_drop = 1'b1;
            issue     = 1'b1;
            issue_dat = 8'h10 + W'(k);
            sb_q.push_back(8'h10 + W'(k));
            step();
        end
        issue = 1'b0;
        check("stream_issue_ready_held", 32'(ir_drop), 32'd0);
        check("stream_rate_pops", 32'(pop_cnt), 32'd15);
        repeat (5) step();
        check("stream_total_pops", 32'(pop_cnt), 32'd20);
        check("stream_count", 32'(count), 32'd0);
        check("stream_overflow", 32'(overflow_err), 32'd0);
        out_ready = 1'b0;

        // 4: post-reset discard window
        force_en  = 1'b1;
        force_vld = 1'b1;
        force_dat = 8'hAA;
        do_reset();
        repeat (P) step();
        force_dat = 8'hBB;
        sb_q.push_back(8'hBB);
        step();
        force_en = 1'b0;
        check("window_count", 32'(count), 32'd1);
        check("window_data", 32'(out_data), 32'hBB);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("window_drained", 32'(count), 32'd0);

        // 5: issue without credit, arrival into full buffer
        do_reset();
        fill(8'h21);
        issue     = 1'b1;
        issue_dat = 8'hEE;
        step();
        issue = 1'b0;
        check("bad_issue_flag", 32'(overflow_err), 32'd1);
        check("bad_issue_credits", 32'(issue_ready), 32'd0);
        force_en  = 1'b1;
        force_vld = 1'b1;
        force_dat = 8'h77;
        step();
        force_en = 1'b0;
        check("drop_count", 32'(count), 32'd8);
        out_ready = 1'b1;
        repeat (D) step();
        out_ready = 1'b0;
        check("drop_drained", 32'(count), 32'd0);
        check("overflow_sticky", 32'(overflow_err), 32'd1);

        // 6: push and pop together while full
        do_reset();
        fill(8'h31);
        force_en  = 1'b1;
        force_vld = 1'b1;
        force_dat = 8'h5A;
        sb_q.push_back(8'h5A);
        out_ready = 1'b1;
        step();
        force_en  = 1'b0;
        out_ready = 1'b0;
        check("full_pushpop_count", 32'(count), 32'd8);
        check("full_pushpop_overflow", 32'(overflow_err), 32'd0);
        out_ready = 1'b1;
        repeat (D) step();
        out_ready = 1'b0;
        check("full_pushpop_drained", 32'(count), 32'd0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_egress_buffer.md
Name: pipe_egress_buffer

Overview:
Credit-managed output buffer at the drain end of a fixed-latency, non-stallable compute pipeline, such as the per-pixel iteration delay line.
- The issuer launches an item only while a credit is free.
- Each item arrives PIPELEN cycles later on pipe_valid/pipe_data and is stored in a circular buffer.
- The buffer is drained to the consumer (framebuffer writer) over a valid/ready handshake.
- Because credits cover items in flight, a pipeline that cannot stall never overflows the buffer.

Parameters:
WIDTH, 32, data word width
DEPTH, 8, buffer entries; power of 2, >= 2; full throughput requires DEPTH >= PIPELEN+2
PIPELEN, 4, issue-to-arrival latency of the upstream pipeline in cycles; also the length of the post-reset discard window

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
issue  in  1  issuer launches an item into the pipeline this cycle
issue_ready  out  1  credit available (credits != 0)
pipe_valid  in  1  pipeline output carries a valid item this cycle
pipe_data  in  WIDTH  pipeline output data
out_valid  out  1  buffer non-empty (count != 0)
out_data  out  WIDTH  entry at the read pointer
out_ready  in  1  consumer accepts; pop = out_valid & out_ready
count  out  clog2(DEPTH+1)  current occupancy
overflow_err  out  1  sticky protocol-error flag

Behaviour:
Interface decision: one clock, named clock; reset is synchronous and active-high, named reset.

Reset:
- Takes effect at the clock edge while reset=1.
- Afterwards: count=0, wr_ptr=rd_ptr=0, credits=DEPTH, out_valid=0, issue_ready=1, overflow_err=0, discard counter=PIPELEN.
- out_data is don't-care while out_valid=0.
- issue and pipe_valid are ignored while reset=1.

Discard window:
- For the first PIPELEN cycles after reset deasserts, pipe_valid is ignored (counter decrements to 0).
- This drops stale items issued before or during reset, including uninitialised valid bits in the delay line.
- issue_ready stays governed by credits during the window. An item issued in window cycle 0 arrives at cycle PIPELEN and is kept.

Credits:
- Accepted issue (issue & issue_ready): credits-1 at the edge.
- Pop: credits+1 at the edge.
- Both in the same cycle: credits unchanged.
- issue while issue_ready=0: ignored, credits unchanged, overflow_err<=1.
- Credits never exceed DEPTH or underflow.

Push and pop:
- Push on pipe_valid (outside the discard window) writes mem[wr_ptr] and increments wr_ptr and count.
- Pop increments rd_ptr and decrements count.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal even when count=DEPTH.
- Push with count=DEPTH and no pop: item dropped, state unchanged, overflow_err<=1.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.

Outputs and latency:
- out_valid = (count != 0); out_data = mem[rd_ptr], a combinational read of the register array.
- An item arriving in cycle t is visible on out_valid/out_data in cycle t+1.
- A credit returned by a pop in cycle c is usable in cycle c+1.
- Issue-to-credit-return loop is PIPELEN+2 cycles.

Error flag:
- overflow_err clears only on reset.
- No invariant other than those listed above is required; credits + count + in-flight = DEPTH holds for legal traffic.

Decomposition:
- Shared package: the default pipeline latency constant (shared with the delay-line instantiation so PIPELEN matches by construction) and a clog2 function.
- Sub-module egress_ring_mem: DEPTH x WIDTH register array with wr_ptr/rd_ptr, write enable and combinational read.
- Credits, count, discard counter and error flag stay in the top.

Test Plan:
Configuration WIDTH=8, DEPTH=8, PIPELEN=4 unless noted.
1. Reset, then out_ready=0, issue=1 in cycles 0..7 with pipe_valid/pipe_data=0x01..0x08 in cycles 4..11 -> issue_ready=0 from cycle 8; count=8 at cycle 12; out_data=0x01.
2. From state 1, raise out_ready -> pops 0x01..0x08 in order, one per cycle; issue_ready=1 the cycle after the first pop; count=0 and out_valid=0 after 8 pops.
3. Stream 20 items with issue held high and out_ready=1 -> order preserved across pointer wrap; 1 item per cycle sustained; issue_ready never drops; overflow_err=0.
4. Reset with pipe_valid=1, data=0xAA held through window cycles 0..3, then 0xBB in cycle 4 -> only 0xBB stored; count=1 at cycle 5.
5. With credits=0, pulse issue -> overflow_err=1; credits unchanged. Force pipe_valid while count=8 and out_ready=0 -> item dropped; count stays 8.
6. With count=8, push 0x5A and pop in the same cycle -> count stays 8; 0x5A becomes the last entry; overflow_err stays 0.
